neuron_layer_sched: RTL and testbench
=====================================

# neuron_layer_sched

Time-multiplexing controller that evaluates one fully-connected layer of NUM_NEURONS two-input neurons on a single shared neuron datapath. Each neuron uses the 16-bit x/w convention: w[0] is the bias, and w[1], w[2] multiply x[0], x[1]. The block holds the layer's weights and accepts one input vector per handshake. It steps a neuron index through the layer, drives the external combinational datapath (linear, ReLU or sigmoid neuron), and streams one result per neuron with a valid/ready handshake.

## Interface
- NUM_NEURONS, 4, neurons in the layer; legal range 1..16
- IDX_W, $clog2(NUM_NEURONS) (min 1), width of neuron index
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low; one clock; reset is synchronous and active-low
- cfg_we  in  1  weight write strobe
- cfg_nidx  in  IDX_W  neuron index of the write
- cfg_widx  in  2  weight slot 0..2 (0 = bias)
- cfg_wdata  in  16  weight value
- cfg_err  out  1  one-cycle pulse when a write is dropped
- in_valid / in_ready  in / out  1  input-vector handshake
- in_x  in  [1:0][15:0]  input vector
- dp_x  out  [1:0][15:0]  operands to the shared datapath
- dp_w  out  [2:0][15:0]  weights to the shared datapath
- dp_y  in  16  datapath result (combinational from dp_x, dp_w)
- out_valid / out_ready  out / in  1  result handshake
- out_y  out  16  neuron result
- out_idx  out  IDX_W  index of the neuron that produced out_y
- out_last  out  1  high with the result of neuron NUM_NEURONS-1
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, EVAL, (WAIT, only with DP_OUT_REG_EN), OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_x into x_q, set k=0, go to EVAL.
- EVAL:
  - dp_x=x_q and dp_w=wfile[k].
  - Without the macro, capture dp_y into out_y and go to OUT.
  - With the macro, go to WAIT; WAIT captures the registered dp_y and goes to OUT.
- OUT:
  - out_valid=1; out_y, out_idx=k and out_last=(k==NUM_NEURONS-1) are held stable until out_ready.
  - On out_valid&&out_ready: if out_last, go to IDLE; else k=k+1 and go to EVAL.
- dp_x and dp_w are driven with x_q and wfile[k] in every state (no toggling to zero); they are don't-care outside EVAL/WAIT.
- Weight file: NUM_NEURONS×3 words, all reset to 0.
  - A write is accepted only in IDLE with cfg_nidx<NUM_NEURONS and cfg_widx≤2.
  - Any other cfg_we is dropped and cfg_err pulses the next cycle.
  - A write and an input acceptance in the same IDLE cycle are both honoured. The write lands in the file and is visible from the first EVAL.
- No arithmetic in the controller; all 16-bit values pass through unmodified. k wraps only via return to IDLE.
- Reset mid-operation: state→IDLE, k=0, x_q=0, the in-flight vector is discarded, and weights are cleared.

## Timing
- Reset values: in_ready=1 (when rst_n is released), out_valid=0, out_y=0, out_idx=0, out_last=0, busy=0, cfg_err=0, dp_x=0, dp_w=0.
- The input accepted at edge T puts neuron 0 in EVAL during cycle T+1. out_valid rises at T+2 (T+3 with the macro).
- Per-neuron cost with out_ready held high: 2 cycles (3 with the macro).
- Full layer takes 2·NUM_NEURONS cycles from acceptance to IDLE (3·NUM_NEURONS with the macro); in_ready returns the cycle after the last handshake.
- Back-pressure: out_ready low stalls in OUT indefinitely with all outputs stable.

## Configuration
- DP_OUT_REG_EN: defined, the controller inserts WAIT for a datapath that has one output register stage. Undefined, dp_y is sampled in EVAL (purely combinational datapath). No other behaviour differs.

## Structure
- Shared package nn_pkg holds:
  - typedef word_t (logic [15:0]), vec2_t ([1:0] word_t), wvec_t ([2:0] word_t);
  - constant N_WEIGHTS=3;
  - the FSM state enum.
- One sub-module, neuron_wfile: the weight register file with one write port (from cfg) and one asynchronous read port indexed by k.

## Test plan
The bench stub datapath is dp_y = dp_x[0] + dp_w[0] + dp_w[1] (integer), delayed by one register with the macro.
- Reset: program bias[n]=n·16 for all n; reset mid-EVAL → out_valid=0, busy=0, then one vector yields out_y=0 for all neurons (weights cleared).
- Nominal: NUM_NEURONS=4; bias=10,20,30,40; w1=1; in_x[0]=5; out_ready=1 → out_y=16,26,36,46 with out_idx 0..3, out_last only on 46, out_valid first at T+2.
- Back-pressure: hold out_ready=0 for 5 cycles on neuron 1 → out_y=26 and out_idx=1 stable for all 5 cycles; the sequence then completes unchanged.
- Config guard: cfg_we while busy and cfg_widx=3 in IDLE → cfg_err pulses once each, weights unchanged.
- Same-cycle write and accept: in IDLE, write bias[0]=100 while accepting in_x[0]=1 → first out_y=102 (with w1=1).
- Back-to-back vectors with in_valid held high: the second vector is accepted the cycle after the first vector's last handshake, and no results are lost.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types for the neuron layer scheduler: data words, operand/weight vectors, FSM states.
// The WAIT state exists only when DP_OUT_REG_EN is defined (registered datapath output).
package nn_pkg;

   typedef logic [15:0] word_t;
   typedef word_t [1:0] vec2_t;
   typedef word_t [2:0] wvec_t;

   localparam int N_WEIGHTS = 3;

`ifdef DP_OUT_REG_EN
   typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_WAIT, ST_OUT} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_OUT} state_t;
`endif

endpackage

// File: rtl/neuron_wfile.sv
// Layer weight file: NUM_NEURONS x 3 words, one synchronous write port, one asynchronous read port.
// Cleared to zero by reset; write legality is decided by the caller.
module neuron_wfile
   import nn_pkg::*;
#(
   parameter int NUM_NEURONS = 4,
   parameter int IDX_W       = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [IDX_W-1:0]     nidx,
   input  logic [1:0]           widx,
   input  logic [15:0]          wdata,
   input  logic [IDX_W-1:0]     ridx,
   output logic [2:0][15:0]     rdata
);

   wvec_t mem [NUM_NEURONS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[nidx][widx] <= wdata;
      end
   end

   assign rdata = mem[ridx];

endmodule

// File: rtl/neuron_layer_sched.sv
// Time-multiplexes one shared two-input neuron datapath across a layer; one result per neuron out.
// Optional macro DP_OUT_REG_EN adds a WAIT state for a datapath with one output register stage.
module neuron_layer_sched
#(
   parameter int NUM_NEURONS = 4,
   parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_we,
   input  logic [IDX_W-1:0]     cfg_nidx,
   input  logic [1:0]           cfg_widx,
   input  logic [15:0]          cfg_wdata,
   output logic                 cfg_err,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0][15:0]     in_x,
   output logic [1:0][15:0]     dp_x,
   output logic [2:0][15:0]     dp_w,
   input  logic [15:0]          dp_y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [15:0]          out_y,
   output logic [IDX_W-1:0]     out_idx,
   output logic                 out_last,
   output logic                 busy
);
   import nn_pkg::*;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] k;
   vec2_t            x_q;
   word_t            y_q;
   logic             err_q;
   wvec_t            w_rd;
   logic             last;
   logic             cfg_ok;
   logic             sample;

   assign last   = (k == IDX_W'(NUM_NEURONS - 1));
   assign cfg_ok = cfg_we && (state == ST_IDLE)
                   && ({1'b0, cfg_nidx} < (IDX_W + 1)'(NUM_NEURONS))
                   && (cfg_widx < 2'(N_WEIGHTS));

   neuron_wfile #(
      .NUM_NEURONS (NUM_NEURONS),
      .IDX_W       (IDX_W)
   ) u_wfile (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (cfg_ok),
      .nidx  (cfg_nidx),
      .widx  (cfg_widx),
      .wdata (cfg_wdata),
      .ridx  (k),
      .rdata (w_rd)
   );

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ST_EVAL;
         end
`ifdef DP_OUT_REG_EN
         ST_EVAL: state_nxt = ST_WAIT;
         ST_WAIT: state_nxt = ST_OUT;
`else
         ST_EVAL: state_nxt = ST_OUT;
`endif
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = last ? ST_IDLE : ST_EVAL;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Registered datapath needs one extra cycle before its result is valid.
`ifdef DP_OUT_REG_EN
   assign sample = (state == ST_WAIT);
`else
   assign sample = (state == ST_EVAL);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         k     <= '0;
         x_q   <= '0;
         y_q   <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         err_q <= cfg_we && !cfg_ok;
         if ((state == ST_IDLE) && in_valid) begin
            x_q <= in_x;
            k   <= '0;
         end
         if (sample) y_q <= dp_y;
         if ((state == ST_OUT) && out_ready && !last) k <= k + IDX_W'(1);
      end
   end

   assign dp_x     = x_q;
   assign dp_w     = w_rd;
   assign out_y    = y_q;
   assign out_idx  = k;
   assign out_last = (state == ST_OUT) && last;
   assign busy     = (state != ST_IDLE);
   assign cfg_err  = err_q;

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Bench for neuron_layer_sched with a stub datapath y = x0 + bias + w1 (registered under DP_OUT_REG_EN).
// Expected results come from a per-neuron weight array and plain 16-bit arithmetic.
module tb_neuron_layer_sched;

   localparam int N     = 4;
   localparam int IDX_W = 2;
`ifdef DP_OUT_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cfg_we = 1'b0;
   logic [IDX_W-1:0]  cfg_nidx = '0;
   logic [1:0]        cfg_widx = '0;
   logic [15:0]       cfg_wdata = '0;
   logic              cfg_err;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [1:0][15:0]  in_x = '0;
   logic [1:0][15:0]  dp_x;
   logic [2:0][15:0]  dp_w;
   logic [15:0]       dp_y;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [15:0]       out_y;
   logic [IDX_W-1:0]  out_idx;
   logic              out_last;
   logic              busy;

   int vectors = 0;
   int miscompares = 0;
   logic [15:0] mw [N][3];

   always #5 clk = ~clk;

   logic [15:0] dp_y_c;
   assign dp_y_c = dp_x[0] + dp_w[0] + dp_w[1];
`ifdef DP_OUT_REG_EN
   always @(posedge clk) dp_y <= dp_y_c;
`else
   assign dp_y = dp_y_c;
`endif

   neuron_layer_sched #(.NUM_NEURONS(N), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_nidx  (cfg_nidx),
      .cfg_widx  (cfg_widx),
      .cfg_wdata (cfg_wdata),
      .cfg_err   (cfg_err),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .dp_x      (dp_x),
      .dp_w      (dp_w),
      .dp_y      (dp_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int n = 0; n < N; n++)
         for (int s = 0; s < 3; s++)
            mw[n][s] = '0;
   endtask

   task automatic wr(input int n, input int slot, input logic [15:0] d, input bit ok);
      cfg_we    = 1'b1;
      cfg_nidx  = IDX_W'(n);
      cfg_widx  = 2'(slot);
      cfg_wdata = d;
      step();
      cfg_we = 1'b0;
      chk("cfg_err", 64'(cfg_err), 64'(!ok));
      if (ok) mw[n][slot] = d;
   endtask

   task automatic accept(input logic [15:0] x0, input logic [15:0] x1, input bit keep);
      in_valid = 1'b1;
      in_x[0]  = x0;
      in_x[1]  = x1;
      chk("in_ready", 64'(in_ready), 64'(1));
      step();
      if (!keep) in_valid = 1'b0;
      chk("busy_accept", 64'(busy), 64'(1));
   endtask

   task automatic drain(input logic [15:0] x0, input logic [15:0] x1,
                        input int stall_n, input int stall_len, input bit chk_first);
      for (int n = 0; n < N; n++) begin
         int cnt;
         logic [15:0] ey;
         cnt = 0;
         while (!out_valid && cnt < 10) begin
            step();
            cnt++;
         end
         if (n > 0 || chk_first) chk("latency", 64'(cnt), 64'(LAT - 1));
         ey = x0 + mw[n][0] + mw[n][1];
         chk("out_y", 64'(out_y), 64'(ey));
         chk("out_idx", 64'(out_idx), 64'(n));
         chk("out_last", 64'(out_last), 64'(n == N - 1));
         chk("dp_x", 64'(dp_x), 64'({x1, x0}));
         chk("dp_w", 64'(dp_w), 64'({mw[n][2], mw[n][1], mw[n][0]}));
         if (n == stall_n) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               step();
               chk("stall_vld", 64'(out_valid), 64'(1));
               chk("stall_y", 64'(out_y), 64'(ey));
               chk("stall_idx", 64'(out_idx), 64'(n));
            end
            out_ready = 1'b1;
         end
         step();
      end
      chk("end_busy", 64'(busy), 64'(0));
      chk("end_ready", 64'(in_ready), 64'(1));
      chk("end_vld", 64'(out_valid), 64'(0));
   endtask

   initial begin
      logic [15:0] a, b, c, d;
      clear_model();

      // Reset values
      step();
      step();
      rst_n = 1'b1;
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_y", 64'(out_y), 64'(0));
      chk("rst_out_idx", 64'(out_idx), 64'(0));
      chk("rst_out_last", 64'(out_last), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_cfg_err", 64'(cfg_err), 64'(0));
      chk("rst_dp_x", 64'(dp_x), 64'(0));
      chk("rst_dp_w", 64'(dp_w), 64'(0));

      // Reset mid-EVAL clears everything including weights
      for (int n = 0; n < N; n++) wr(n, 0, 16'(n * 16), 1'b1);
      accept(16'd3, 16'd9, 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      clear_model();
      chk("mid_rst_vld", 64'(out_valid), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_dp_x", 64'(dp_x), 64'(0));
      chk("mid_rst_dp_w", 64'(dp_w), 64'(0));
      accept(16'd0, 16'd0, 1'b0);
      drain(16'd0, 16'd0, -1, 0, 1'b1);

      // Nominal layer: 16, 26, 36, 46
      for (int n = 0; n < N; n++) begin
         wr(n, 0, 16'((n + 1) * 10), 1'b1);
         wr(n, 1, 16'd1, 1'b1);
      end
      a = 16'($urandom);
      accept(16'd5, a, 1'b0);
      drain(16'd5, a, -1, 0, 1'b1);

      // Back-pressure on neuron 1 for 5 cycles
      accept(16'd5, a, 1'b0);
      drain(16'd5, a, 1, 5, 1'b1);

      // Illegal slot in IDLE, then write while busy
      wr(0, 3, 16'd777, 1'b0);
      step();
      chk("err_pulse_once_a", 64'(cfg_err), 64'(0));
      out_ready = 1'b0;
      accept(16'd2, 16'd0, 1'b0);
      wr(0, 0, 16'd999, 1'b0);
      step();
      chk("err_pulse_once_b", 64'(cfg_err), 64'(0));
      out_ready = 1'b1;
      drain(16'd2, 16'd0, -1, 0, 1'b0);

      // Same-cycle weight write and input acceptance
      cfg_we    = 1'b1;
      cfg_nidx  = '0;
      cfg_widx  = 2'd0;
      cfg_wdata = 16'd100;
      accept(16'd1, 16'd0, 1'b0);
      cfg_we = 1'b0;
      mw[0][0] = 16'd100;
      chk("same_cyc_err", 64'(cfg_err), 64'(0));
      drain(16'd1, 16'd0, -1, 0, 1'b1);

      // Back-to-back with in_valid held high
      b = 16'($urandom);
      c = 16'($urandom);
      accept(b, 16'd1, 1'b1);
      in_x[0] = c;
      in_x[1] = 16'd2;
      drain(b, 16'd1, -1, 0, 1'b1);
      accept(c, 16'd2, 1'b0);
      drain(c, 16'd2, -1, 0, 1'b1);

      // Randomized weights, inputs and stalls
      for (int it = 0; it < 8; it++) begin
         for (int w = 0; w < 4; w++)
            wr(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 2)), 16'($urandom), 1'b1);
         c = 16'($urandom);
         d = 16'($urandom);
         accept(c, d, 1'b0);
         drain(c, d, int'($urandom_range(0, N)), int'($urandom_range(0, 4)), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
